// File: rtl/ttc_pkg.sv
// Shared types and helpers for the truth table checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ttc_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } ttc_state_t;

  // Smallest legal settle interval: resp needs at least one cycle after stim moves
  localparam int TTC_MIN_SETTLE = 1;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int ttc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ttc_settle_timer.sv
// Settle interval timer: load on entry to SETTLE, count down while enabled.
// Latency: expired is asserted on the SETTLE-th enabled cycle after load.
// Backpressure: none; count holds whenever en is low.
module ttc_settle_timer
  import ttc_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = ttc_width(SETTLE + 1);
  // Loaded with SETTLE-1 so that the count reaches zero in the last settle cycle
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  // Reload at the start of each settle window, then count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 2^N_IN stim vectors, samples resp after SETTLE cycles, compares with exp_tbl.
// Latency: done pulses 2^N_IN*(SETTLE+1)+1 cycles after start is accepted.
// Backpressure: none; start is only accepted in IDLE. Option: TTC_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_checker
  import ttc_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  exp_tbl,
  output logic [N_IN-1:0]       stim,
  input  logic                  resp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_cnt,
  output logic [N_IN-1:0]       first_fail,
  output logic                  first_fail_vld
);

  localparam int NV = 1 << N_IN;
  localparam logic [N_IN:0] ERR_MAX = (N_IN + 1)'(NV);

  ttc_state_t        state_q;
  ttc_state_t        state_d;
  logic [NV-1:0]     exp_tbl_q;
  logic              accept;
  logic              sampling;
  logic              last;
  logic              mismatch;
  logic              finish;
  logic              timer_load;
  logic              timer_en;
  logic              timer_expired;
  logic [N_IN:0]     err_nxt;

  assign accept   = (state_q == ST_IDLE) && start;
  assign sampling = (state_q == ST_SAMPLE);
  assign last     = &stim;
  assign mismatch = sampling && (resp != exp_tbl_q[stim]);
  assign err_nxt  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + (N_IN + 1)'(1) : err_cnt;

`ifdef TTC_STOP_ON_FAIL_EN
  // Abort on the first mismatch; stim stays on the failing index
  assign finish = last | mismatch;
`else
  // Always run the whole sweep
  assign finish = last;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; the end-of-sweep decision is taken before stim can advance
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (timer_expired) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = finish ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs and timer controls derived from the current state
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    timer_en   = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE:   timer_load = start;
      ST_SETTLE: begin
        busy     = 1'b1;
        timer_en = 1'b1;
      end
      ST_SAMPLE: begin
        busy       = 1'b1;
        timer_load = !finish;
      end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  // Sweep datapath: latch table on accept, record mismatches, step stim, settle the verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_tbl_q      <= '0;
      stim           <= '0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      exp_tbl_q      <= exp_tbl;
      stim           <= '0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (sampling) begin
      err_cnt <= err_nxt;
      if (mismatch && !first_fail_vld) begin
        first_fail     <= stim;
        first_fail_vld <= 1'b1;
      end
      if (finish) begin
        // Verdict includes a mismatch seen in this final sample
        pass <= (err_nxt == '0);
      end else begin
        stim <= stim + N_IN'(1);
      end
    end
  end

  ttc_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

endmodule
